// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a 4-bit sync word, shifts in an MSB-first
// payload, then checks an even-parity bit before publishing the payload.
module serial_frame_rx #(
  parameter int         NBITS_DATA   = 8,
  parameter logic [3:0] SYNC_PATTERN = 4'b1011
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [NBITS_DATA-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  busy,
  output logic [1:0]            state_dbg,
  output logic [7:0]            frame_count,
  output logic [3:0]            err_count
);

  localparam int CW = $clog2(NBITS_DATA);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS_DATA - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            window, window_nxt;
  logic [NBITS_DATA-1:0] payload, payload_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [NBITS_DATA-1:0] data_nxt;
  logic                  dv_nxt, pe_nxt;
  logic [7:0]            fc_nxt;
  logic [3:0]            ec_nxt;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      window      <= '0;
      payload     <= '0;
      cnt         <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      window      <= window_nxt;
      payload     <= payload_nxt;
      cnt         <= cnt_nxt;
      data_out    <= data_nxt;
      data_valid  <= dv_nxt;
      parity_err  <= pe_nxt;
      frame_count <= fc_nxt;
      err_count   <= ec_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    window_nxt  = window;
    payload_nxt = payload;
    cnt_nxt     = cnt;
    data_nxt    = data_out;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    fc_nxt      = frame_count;
    ec_nxt      = err_count;
    if (bit_valid) begin
      case (state)
        HUNT: begin
          window_nxt = {window[2:0], bit_in};
          if (window_nxt == SYNC_PATTERN) begin
            state_nxt   = PAYLOAD;
            cnt_nxt     = '0;
            payload_nxt = '0;
          end
        end
        PAYLOAD: begin
          payload_nxt = {payload[NBITS_DATA-2:0], bit_in};
          cnt_nxt     = cnt + 1'b1;
          if (cnt == LAST_BIT) state_nxt = PARITY;
        end
        PARITY: begin
          if (^{payload, bit_in}) begin
            pe_nxt = 1'b1;
            if (err_count != 4'd15) ec_nxt = err_count + 4'd1;
          end else begin
            data_nxt = payload;
            dv_nxt   = 1'b1;
            fc_nxt   = frame_count + 8'd1;
          end
          // Window restarts empty so a new sync cannot borrow frame bits.
          state_nxt  = HUNT;
          window_nxt = '0;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign state_dbg = state;
  assign busy      = (state == PAYLOAD) || (state == PARITY);

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the 4-bit serial/parallel shift register stage.
- Takes the serial bit stream leaving that register (its bit 0) plus a per-bit qualifier.
- Hunts for a fixed sync pattern, deserializes an NBITS_DATA payload MSB-first, then checks an even-parity bit.
- Presents the last good payload, pulse flags and frame/error counters for LED/SEG/LCD display.

Parameters:
NBITS_DATA, 8, payload width in bits (>= 2)
SYNC_PATTERN, 4'b1011, 4-bit sync word; first-received bit is MSB

Ports:
clk_2  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
bit_in  input  1  serial bit from upstream shift register output
bit_valid  input  1  qualifies bit_in; bit consumed only on an edge where it is 1
data_out  output  NBITS_DATA  last payload received with correct parity
data_valid  output  1  one-cycle pulse: data_out just updated
parity_err  output  1  one-cycle pulse: frame discarded on parity mismatch
busy  output  1  high while in PAYLOAD or PARITY
state_dbg  output  2  HUNT=0, PAYLOAD=1, PARITY=2 (3 unused)
frame_count  output  8  good frames received, wraps 255->0
err_count  output  4  parity errors, saturates at 15

Behaviour:
- Reset (async, any state): state=HUNT, sync window=0, payload shift reg=0, bit counter=0, data_out=0, data_valid=0, parity_err=0, busy=0, state_dbg=0, frame_count=0, err_count=0. A frame in progress is aborted with no pulse.
- All outputs are registered. data_valid and parity_err are 0 on every edge that does not set them.
- Edges with bit_valid=0: no state, window, counter or shift change. Pulses still clear.
- HUNT:
  - On each valid bit, window <= {window[2:0], bit_in}.
  - If {window[2:0], bit_in} == SYNC_PATTERN: go to PAYLOAD, bit counter=0, payload reg=0.
  - Sliding/overlapping detection is allowed within HUNT.
- PAYLOAD:
  - On each valid bit, payload <= {payload[NBITS_DATA-2:0], bit_in}, counter++.
  - When the NBITS_DATA-th bit is taken (counter==NBITS_DATA-1), go to PARITY.
- PARITY:
  - On a valid bit, compute p = XOR(payload, bit_in).
  - p==0: data_out <= payload, data_valid <= 1, frame_count <= frame_count+1 (mod 256).
  - p==1: parity_err <= 1, err_count <= min(err_count+1, 15), data_out unchanged.
  - Either case: state -> HUNT, window cleared to 0. No sync overlap across frames.
- Latency: pulses and data_out are visible after the clock edge that samples the parity bit. Frame end to flag is one edge.
- busy and state_dbg reflect the registered state.
- Minimum frame: 4 + NBITS_DATA + 1 valid bits. Back-to-back frames with no gap are accepted.

Test Plan:
1. Basic good frame. After reset, feed valid bits 1,0,1,1 then 0xA5 MSB-first (1,0,1,0,0,1,0,1), parity 0 -> data_out=0xA5, data_valid high exactly one cycle, frame_count=1, err_count=0, busy low afterwards.
2. Parity error. Repeat scenario 1 with parity bit 1 -> parity_err one-cycle pulse, err_count=1, data_out stays 0xA5, frame_count unchanged, no data_valid.
3. Overlapping sync. Bits 1,0,1,0,1,1 -> busy rises after the 6th bit. Then 0x3C (0,0,1,1,1,1,0,0), parity 0 -> data_out=0x3C, data_valid pulse.
4. Valid gaps. Scenario 1 with 0-3 bit_valid=0 cycles between bits and bit_in toggling during gaps -> identical result. state_dbg holds during gaps.
5. Reset mid-payload. Assert reset after 4 payload bits -> state_dbg=0, busy=0, all outputs 0, no pulse. A subsequent full 0x5A frame (parity 0) gives data_out=0x5A, frame_count=1.
6. Counter limits.
   - 17 consecutive bad-parity frames -> err_count stops at 15.
   - 256 good frames from reset -> frame_count returns to 0 with the 256th data_valid pulse.
